// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter that shares one resource among 8 requesters.
// Each grant is held until the owner signals done, drops its request, or a hold
// timeout expires. Every grant is followed by one idle turnaround cycle.
// All outputs are registered, so grant never depends combinationally on req.
module rr_grant_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] grant_sel,
  output logic       grant_valid,
  output logic [7:0] grant,
  output logic       timeout_err,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  // Final hold-count value. It is only consulted when the timeout is enabled.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       last;
  logic [2:0]       win_idx;
  logic             win_found;
  logic [2:0]       cand;

  // Find the first requester after the last grantee, wrapping modulo 8.
  always_comb begin
    win_idx   = last;
    win_found = 1'b0;
    cand      = last;
    for (int i = 1; i <= 8; i++) begin
      cand = last + 3'(i);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Arbitration state machine. It drives the registered grant outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant_sel   <= 3'd0;
      grant_valid <= 1'b0;
      grant       <= 8'h00;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      cnt         <= '0;
      last        <= 3'd7;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (win_found) begin
            grant_sel   <= win_idx;
            grant_valid <= 1'b1;
            grant       <= 8'b0000_0001 << win_idx;
            cnt         <= '0;
            state       <= GRANT;
            busy        <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (done || !req[grant_sel]) begin
            last        <= grant_sel;
            grant_valid <= 1'b0;
            grant       <= 8'h00;
            state       <= GAP;
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            timeout_err <= 1'b1;
            last        <= grant_sel;
            grant_valid <= 1'b0;
            grant       <= 8'h00;
            state       <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
          grant       <= 8'h00;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
